// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular in-order reorder buffer sitting between decode/issue and the
//   architectural register file. Allocates a tag per issued instruction,
//   drives the register-file rename write, captures CDB results, retires the
//   head entry in order (commit write) and answers operand-tag lookups.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global enable; low holds all state
//   issue_valid, issue_rd    allocation request and its destination register
//   issue_tag, rob_full      tag given to the issuing instruction, full flag
//   cdb_valid/tag/val        common data bus result broadcast
//   q1_/q2_tag,ready,val     operand lookups into the buffer
//   rd_in_flag/a/rob         rename write to the register file
//   rd_out_flag/a/val/rob    commit write to the register file (head entry)
//
// Configuration
//   ROB_CDB_BYPASS_EN  when defined, operand lookups also see a CDB result
//                      broadcast in the same cycle; otherwise lookups see
//                      registered state only.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  output logic [TAG_W-1:0] issue_tag,
  output logic             rob_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_val,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_val,
  output logic [31:0]      q2_val,
  output logic             rd_in_flag,
  output logic [4:0]       rd_in_a,
  output logic [TAG_W-1:0] rd_in_rob,
  output logic             rd_out_flag,
  output logic [4:0]       rd_out_a,
  output logic [31:0]      rd_out_val,
  output logic [TAG_W-1:0] rd_out_rob
);

  logic [ROB_DEPTH-1:0] busy_q, ready_q;
  logic [4:0]           rd_q  [ROB_DEPTH];
  logic [31:0]          val_q [ROB_DEPTH];
  logic [TAG_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]       count_q, count_d;

  logic accepted, can_commit;

  assign rob_full  = (count_q == (TAG_W+1)'(ROB_DEPTH));
  assign issue_tag = tail_q;
  assign accepted  = rdy & issue_valid & ~rob_full;

  assign rd_in_flag = accepted & (issue_rd != 5'd0);
  assign rd_in_a    = issue_rd;
  assign rd_in_rob  = tail_q;

  // The register file has a single write port that prefers rename, so a
  // ready head is held back for one cycle whenever a rename write is issued.
  assign can_commit  = rdy & busy_q[head_q] & ready_q[head_q] & ~rd_in_flag;
  assign rd_out_flag = can_commit & (rd_q[head_q] != 5'd0);
  assign rd_out_a    = rd_q[head_q];
  assign rd_out_val  = val_q[head_q];
  assign rd_out_rob  = head_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (can_commit) head_d = head_q + TAG_W'(1);
    if (accepted)   tail_d = tail_q + TAG_W'(1);
    case ({accepted, can_commit})
      2'b10:   count_d = count_q + (TAG_W+1)'(1);
      2'b01:   count_d = count_q - (TAG_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    q1_ready = busy_q[q1_tag] & ready_q[q1_tag];
    q1_val   = val_q[q1_tag];
    q2_ready = busy_q[q2_tag] & ready_q[q2_tag];
    q2_val   = val_q[q2_tag];
`ifdef ROB_CDB_BYPASS_EN
    // Forward a result being broadcast this cycle so a waiting RS entry
    // does not lose a cycle; commit still relies on the registered bit.
    if (cdb_valid && busy_q[q1_tag] && (cdb_tag == q1_tag)) begin
      q1_ready = 1'b1;
      q1_val   = cdb_val;
    end
    if (cdb_valid && busy_q[q2_tag] && (cdb_tag == q2_tag)) begin
      q2_ready = 1'b1;
      q2_val   = cdb_val;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      ready_q <= '0;
      // Entry contents are cleared too so the head-facing outputs read zero
      // straight out of reset.
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rd_q[i]  <= '0;
        val_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (rdy && cdb_valid && busy_q[cdb_tag]) begin
        ready_q[cdb_tag] <= 1'b1;
        val_q[cdb_tag]   <= cdb_val;
      end
      // Issue targets a free entry, so it never collides with a CDB hit.
      if (accepted) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        rd_q[tail_q]    <= issue_rd;
      end
      if (can_commit) begin
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy, issue_valid, cdb_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_tag, cdb_tag, q1_tag, q2_tag, rd_in_rob, rd_out_rob;
  logic [31:0] cdb_val, q1_val, q2_val, rd_out_val;
  logic        rob_full, q1_ready, q2_ready, rd_in_flag, rd_out_flag;
  logic [4:0]  rd_in_a, rd_out_a;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] v;
    logic [3:0]  r;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_DEPTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_tag(issue_tag), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .q1_tag(q1_tag), .q2_tag(q2_tag),
    .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .rd_in_flag(rd_in_flag), .rd_in_a(rd_in_a), .rd_in_rob(rd_in_rob),
    .rd_out_flag(rd_out_flag), .rd_out_a(rd_out_a),
    .rd_out_val(rd_out_val), .rd_out_rob(rd_out_rob)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] v, input logic [3:0] r);
    exp_t e;
    e.a = a; e.v = v; e.r = r;
    exp_q.push_back(e);
  endtask

  // Commit monitor: every register-file commit write must match the oldest
  // expected retirement.
  always @(negedge clk) begin
    if (!rst && rd_out_flag) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_commit_rob", {28'd0, rd_out_rob}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_a",   {27'd0, rd_out_a},   {27'd0, e.a});
        chk("commit_val", rd_out_val,          e.v);
        chk("commit_rob", {28'd0, rd_out_rob}, {28'd0, e.r});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; issue_valid = 1'b0; issue_rd = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; q1_tag = '0; q2_tag = '0;
    step(); step();
    rst = 1'b0;

    // Reset mid-stream with five busy entries, competing issue and CDB
    for (int i = 0; i < 5; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i + 1);
      step();
    end
    rst = 1'b1; issue_valid = 1'b1; issue_rd = 5'd7;
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_val = 32'h9999;
    step();
    rst = 1'b0; issue_valid = 1'b0; cdb_valid = 1'b0; q1_tag = 4'd0;
    @(negedge clk);
    chk("rst_full",     {31'd0, rob_full},    32'd0);
    chk("rst_in_flag",  {31'd0, rd_in_flag},  32'd0);
    chk("rst_out_flag", {31'd0, rd_out_flag}, 32'd0);
    chk("rst_tag",      {28'd0, issue_tag},   32'd0);
    chk("rst_out_a",    {27'd0, rd_out_a},    32'd0);
    chk("rst_out_val",  rd_out_val,           32'd0);
    chk("rst_q1_ready", {31'd0, q1_ready},    32'd0);
    step();

    // Issue rd=3, CDB at edge N, retire at edge N+1
    issue_valid = 1'b1; issue_rd = 5'd3;
    @(negedge clk);
    chk("t2_in_flag", {31'd0, rd_in_flag}, 32'd1);
    chk("t2_in_a",    {27'd0, rd_in_a},    32'd3);
    chk("t2_in_rob",  {28'd0, rd_in_rob},  32'd0);
    step();
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_val = 32'h1234;
    push(5'd3, 32'h1234, 4'd0);
    @(negedge clk);
    chk("t2_not_yet", {31'd0, rd_out_flag}, 32'd0);
    step();
    cdb_valid = 1'b0;
    @(negedge clk);
    chk("t2_out_flag", {31'd0, rd_out_flag}, 32'd1);
    step();
    @(negedge clk);
    chk("t2_head_after", {28'd0, rd_out_rob}, 32'd1);
    chk("t2_flag_after", {31'd0, rd_out_flag}, 32'd0);
    step();

    // rd=0 retires silently; CDB to a free entry is dropped
    issue_valid = 1'b1; issue_rd = 5'd0;
    @(negedge clk);
    chk("t5_in_flag", {31'd0, rd_in_flag}, 32'd0);
    chk("t5_tag",     {28'd0, issue_tag},  32'd1);
    step();
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_val = 32'h55;
    step();
    cdb_valid = 1'b0;
    @(negedge clk);
    chk("t5_out_flag", {31'd0, rd_out_flag}, 32'd0);
    chk("t5_out_rob",  {28'd0, rd_out_rob},  32'd1);
    chk("t5_out_val",  rd_out_val,           32'h55);
    step();
    @(negedge clk);
    chk("t5_head_inc", {28'd0, rd_out_rob}, 32'd2);
    step();
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_val = 32'hDEAD;
    step();
    cdb_valid = 1'b0; q1_tag = 4'd7;
    @(negedge clk);
    chk("t5_drop_ready", {31'd0, q1_ready}, 32'd0);
    chk("t5_drop_val",   q1_val,            32'd0);
    chk("t5_drop_head",  {28'd0, rd_out_rob}, 32'd2);
    step();

    // Rename write blocks a ready head for one cycle
    issue_valid = 1'b1; issue_rd = 5'd4;
    step();
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_val = 32'hAA;
    step();
    cdb_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd5;
    push(5'd4, 32'hAA, 4'd2);
    @(negedge clk);
    chk("t4_in_flag",  {31'd0, rd_in_flag},  32'd1);
    chk("t4_out_flag", {31'd0, rd_out_flag}, 32'd0);
    chk("t4_head",     {28'd0, rd_out_rob},  32'd2);
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("t4_retry_flag", {31'd0, rd_out_flag}, 32'd1);
    step();
    @(negedge clk);
    chk("t4_head_inc", {28'd0, rd_out_rob}, 32'd3);
    step();

    // Operand lookup against a same-cycle CDB broadcast
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i + 1);
      step();
    end
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_val = 32'hBEEF;
    q1_tag = 4'd2; q2_tag = 4'd1;
    @(negedge clk);
`ifdef ROB_CDB_BYPASS_EN
    chk("t6_byp_ready", {31'd0, q1_ready}, 32'd1);
    chk("t6_byp_val",   q1_val,            32'hBEEF);
`else
    chk("t6_reg_ready", {31'd0, q1_ready}, 32'd0);
`endif
    chk("t6_q2_ready", {31'd0, q2_ready}, 32'd0);
    step();
    cdb_valid = 1'b0;
    @(negedge clk);
    chk("t6_next_ready", {31'd0, q1_ready}, 32'd1);
    chk("t6_next_val",   q1_val,            32'hBEEF);
    step();

    // Fill, overflow attempt, wrap, commit with concurrent issue
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i + 1);
      if (i == 15) begin
        @(negedge clk);
        chk("t3_not_full_15", {31'd0, rob_full}, 32'd0);
      end
      step();
    end
    issue_valid = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    chk("t3_full",        {31'd0, rob_full},   32'd1);
    chk("t3_17th_flag",   {31'd0, rd_in_flag}, 32'd0);
    chk("t3_tag_wrapped", {28'd0, issue_tag},  32'd0);
    step();
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_val = 32'h100;
    push(5'd1, 32'h100, 4'd0);
    @(negedge clk);
    chk("t3_tail_held", {28'd0, issue_tag}, 32'd0);
    chk("t3_still_full", {31'd0, rob_full}, 32'd1);
    step();
    cdb_tag = 4'd1; cdb_val = 32'h101;
    push(5'd2, 32'h101, 4'd1);
    @(negedge clk);
    chk("t3_full_at_commit", {31'd0, rob_full}, 32'd1);
    step();
    cdb_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    @(negedge clk);
    chk("t3_both_in_flag", {31'd0, rd_in_flag}, 32'd0);
    chk("t3_both_tag",     {28'd0, issue_tag},  32'd0);
    chk("t3_both_full",    {31'd0, rob_full},   32'd0);
    step();
    issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    chk("t3_refill_flag", {31'd0, rd_in_flag}, 32'd1);
    chk("t3_refill_tag",  {28'd0, issue_tag},  32'd1);
    chk("t3_refill_nf",   {31'd0, rob_full},   32'd0);
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("t3_full_again", {31'd0, rob_full}, 32'd1);
    step();

    chk("pending_commits", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
